adiv5_arb_ctrl: RTL and testbench
=================================

ADIV5_ARB_CTRL -- requirements
Module: adiv5_arb_ctrl

Interface
REQ-001 SHALL have parameter TAG_DEPTH, default 4: outstanding-command tag FIFO depth; power of 2, minimum 2.
REQ-002 SHALL have parameter SETTLE, default 8: idle cycles held after a mode change; range 1..255.
REQ-003 SHALL have port CLK, input, 1: the single clock; all state is sampled on its rising edge.
REQ-004 SHALL have port RESET, input, 1: reset, asynchronous assertion, active-high.
REQ-005 SHALL have ports A_WRDATA input 36, A_WREN input 1, A_WRFULL output 1: command write interface for requester A.
REQ-006 SHALL have ports A_RDDATA output 35, A_RDEN input 1, A_RDEMPTY output 1: response read interface for requester A.
REQ-007 SHALL have ports B_WRDATA, B_WREN, B_WRFULL, B_RDDATA, B_RDEN, B_RDEMPTY: requester B, identical widths to A.
REQ-008 SHALL have ports M_WRDATA output 36, M_WREN output 1, M_WRFULL input 1: downstream ADIv5 command FIFO.
REQ-009 SHALL have ports M_RDDATA input 35, M_RDEN output 1, M_RDEMPTY input 1: downstream ADIv5 response FIFO.
REQ-010 SHALL have ports MODE_REQ input 1, MODE_JTAG input 1, MODE_DIRECT input 1: single-cycle mode-change request and its target mode.
REQ-011 SHALL have ports JTAGnSWD output 1, JTAG_DIRECT output 1, MODE_BUSY output 1, MODE_DONE output 1: registered mode selects, busy flag, and one-cycle completion pulse.

Function
REQ-012 SHALL hold one command per requester in a hold register (HA, HB), each with a valid flag.
REQ-013 SHALL accept a write when xWREN=1 and xWRFULL=0; a write while xWRFULL=1 is dropped.
REQ-014 SHALL drive xWRFULL = (Hx valid and Hx not issued this cycle) or state is not RUN.
REQ-015 SHALL issue a command when M_WRFULL=0, tag count < TAG_DEPTH, and at least one hold register is valid.
REQ-016 SHALL drive M_WREN=1 and M_WRDATA from the selected hold register combinationally in the issue cycle, and clear that register's valid flag.
REQ-017 SHALL arbitrate round-robin: with both HA and HB valid, the requester not served last wins; the last-served flag resets to B, so A wins the first conflict.
REQ-018 SHALL push the issuing requester ID into the tag FIFO on every issue; the full check uses the count before any same-cycle pop.
REQ-019 SHALL deassert A_RDEMPTY only when M_RDEMPTY=0, the tag FIFO is non-empty, and the head tag is A; B_RDEMPTY follows the same rule with head tag B.
REQ-020 SHALL drive A_RDDATA and B_RDDATA directly from M_RDDATA.
REQ-021 SHALL drive M_RDEN = (A_RDEN and not A_RDEMPTY) or (B_RDEN and not B_RDEMPTY), and pop the tag FIFO on M_RDEN; an xRDEN while xRDEMPTY=1 is ignored.
REQ-022 SHALL keep both xRDEMPTY=1 and M_RDEN=0 when a response is present but the tag FIFO is empty (orphan response; not consumed).
REQ-023 SHALL allow a tag FIFO push and pop in the same cycle, leaving the count unchanged; pointers wrap modulo TAG_DEPTH.
REQ-024 SHALL implement the mode FSM with states RUN, DRAIN, SWITCH, SETTLE.
REQ-025 SHALL, in RUN on MODE_REQ=1, latch MODE_JTAG and MODE_DIRECT and move to DRAIN; MODE_REQ in any other state is ignored.
REQ-026 SHALL, in DRAIN, continue issuing hold-register commands and routing responses, and move to SWITCH once HA, HB and the tag FIFO are all empty.
REQ-027 SHALL, in SWITCH, last exactly one cycle, load JTAGnSWD and JTAG_DIRECT from the latched values, load the settle counter with SETTLE, and move to SETTLE.
REQ-028 SHALL, in SETTLE, decrement the counter each cycle and on reaching 0 move to RUN with MODE_DONE=1 for that one cycle.
REQ-029 SHALL run the full DRAIN/SWITCH/SETTLE sequence even when the requested mode equals the current mode.
REQ-030 SHALL drive MODE_BUSY=1 whenever the state is not RUN.

Reset
REQ-031 SHALL, on RESET=1, set state RUN, clear HA, HB and the tag FIFO, set last-served=B, counter 0, JTAGnSWD=1, JTAG_DIRECT=0, MODE_DONE=0, MODE_BUSY=0.
REQ-032 SHALL abandon any in-flight drain or settle when RESET is asserted mid-operation, and keep the mode outputs at their reset values.

Verification
REQ-033 SHALL cover arbitration conflict: A and B both write in the same cycle, M_WRFULL=0 -> A issued first, B the next cycle; the tag FIFO holds A,B.
REQ-034 SHALL cover in-order routing: two responses queued with tags A,B -> only A_RDEMPTY=0; after A_RDEN, B_RDEMPTY=0.
REQ-035 SHALL cover tag full: TAG_DEPTH=4, 4 commands issued and no responses -> fifth command held, M_WREN=0 until one response is read.
REQ-036 SHALL cover a mode switch with one outstanding command: MODE_REQ with JTAG=0, DIRECT=0 -> both xWRFULL=1; after the response is read, JTAGnSWD=0 one cycle later; MODE_DONE pulses SETTLE=8 cycles after that.
REQ-037 SHALL cover reset mid-SETTLE: RESET asserted -> JTAGnSWD=1, MODE_BUSY=0 immediately and no MODE_DONE pulse.
REQ-038 SHALL cover an orphan response: M_RDEMPTY=0 with the tag FIFO empty -> M_RDEN stays 0 and both xRDEMPTY stay 1.

Source files
------------

// File: rtl/adiv5_arb_ctrl.sv
// Two-requester arbiter in front of an ADIv5 command/response FIFO pair.
// Responses are routed by an in-order tag FIFO; mode changes drain all traffic first.
module adiv5_arb_ctrl #(
    parameter int unsigned TAG_DEPTH = 4,
    parameter int unsigned SETTLE    = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [35:0] A_WRDATA,
    input  logic        A_WREN,
    output logic        A_WRFULL,
    output logic [34:0] A_RDDATA,
    input  logic        A_RDEN,
    output logic        A_RDEMPTY,
    input  logic [35:0] B_WRDATA,
    input  logic        B_WREN,
    output logic        B_WRFULL,
    output logic [34:0] B_RDDATA,
    input  logic        B_RDEN,
    output logic        B_RDEMPTY,
    output logic [35:0] M_WRDATA,
    output logic        M_WREN,
    input  logic        M_WRFULL,
    input  logic [34:0] M_RDDATA,
    output logic        M_RDEN,
    input  logic        M_RDEMPTY,
    input  logic        MODE_REQ,
    input  logic        MODE_JTAG,
    input  logic        MODE_DIRECT,
    output logic        JTAGnSWD,
    output logic        JTAG_DIRECT,
    output logic        MODE_BUSY,
    output logic        MODE_DONE
);
    localparam int unsigned PW = $clog2(TAG_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SWITCH, ST_SETTLE} state_t;

    state_t                 r_state;
    logic [35:0]            r_ha_data;
    logic [35:0]            r_hb_data;
    logic                   r_ha_vld;
    logic                   r_hb_vld;
    logic                   r_last_b;
    logic [TAG_DEPTH-1:0]   r_tag;
    logic [PW-1:0]          r_wp;
    logic [PW-1:0]          r_rp;
    logic [CW-1:0]          r_cnt;
    logic [7:0]             r_settle;
    logic                   r_tgt_jtag;
    logic                   r_tgt_direct;

    logic                   w_run;
    logic                   w_issue;
    logic                   w_sel_b;
    logic                   w_iss_a;
    logic                   w_iss_b;
    logic                   w_wr_a;
    logic                   w_wr_b;
    logic                   w_rsp;
    logic                   w_head_b;
    logic                   w_ha_vld_nxt;
    logic                   w_hb_vld_nxt;
    logic [CW-1:0]          w_cnt_nxt;
    logic                   w_drained;

    assign w_run    = (r_state == ST_RUN);
    assign w_issue  = !M_WRFULL && (r_cnt < CW'(TAG_DEPTH)) && (r_ha_vld || r_hb_vld);
    // On a conflict the requester not served last wins.
    assign w_sel_b  = r_hb_vld && (!r_ha_vld || !r_last_b);
    assign w_iss_a  = w_issue && !w_sel_b;
    assign w_iss_b  = w_issue && w_sel_b;

    assign A_WRFULL = (r_ha_vld && !w_iss_a) || !w_run;
    assign B_WRFULL = (r_hb_vld && !w_iss_b) || !w_run;
    assign w_wr_a   = A_WREN && !A_WRFULL;
    assign w_wr_b   = B_WREN && !B_WRFULL;

    assign M_WREN   = w_issue;
    assign M_WRDATA = w_sel_b ? r_hb_data : r_ha_data;

    assign w_head_b  = r_tag[r_rp];
    assign w_rsp     = !M_RDEMPTY && (r_cnt != '0);
    assign A_RDEMPTY = !(w_rsp && !w_head_b);
    assign B_RDEMPTY = !(w_rsp && w_head_b);
    assign M_RDEN    = (A_RDEN && !A_RDEMPTY) || (B_RDEN && !B_RDEMPTY);
    assign A_RDDATA  = M_RDDATA;
    assign B_RDDATA  = M_RDDATA;

    // Drain completion looks at post-edge occupancy so SWITCH follows the last pop directly.
    assign w_ha_vld_nxt = w_wr_a || (r_ha_vld && !w_iss_a);
    assign w_hb_vld_nxt = w_wr_b || (r_hb_vld && !w_iss_b);
    assign w_cnt_nxt    = r_cnt + CW'(w_issue) - CW'(M_RDEN);
    assign w_drained    = !w_ha_vld_nxt && !w_hb_vld_nxt && (w_cnt_nxt == '0);

    assign MODE_BUSY = !w_run;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_ha_data <= '0;
            r_hb_data <= '0;
            r_ha_vld  <= 1'b0;
            r_hb_vld  <= 1'b0;
            r_last_b  <= 1'b1;
            r_tag     <= '0;
            r_wp      <= '0;
            r_rp      <= '0;
            r_cnt     <= '0;
        end else begin
            r_ha_vld <= w_ha_vld_nxt;
            r_hb_vld <= w_hb_vld_nxt;
            if (w_wr_a) r_ha_data <= A_WRDATA;
            if (w_wr_b) r_hb_data <= B_WRDATA;
            if (w_issue) begin
                r_last_b    <= w_sel_b;
                r_tag[r_wp] <= w_sel_b;
                r_wp        <= r_wp + 1'b1;
            end
            if (M_RDEN) r_rp <= r_rp + 1'b1;
            r_cnt <= w_cnt_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= ST_RUN;
            r_settle     <= '0;
            r_tgt_jtag   <= 1'b1;
            r_tgt_direct <= 1'b0;
            JTAGnSWD     <= 1'b1;
            JTAG_DIRECT  <= 1'b0;
            MODE_DONE    <= 1'b0;
        end else begin
            MODE_DONE <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (MODE_REQ) begin
                        r_tgt_jtag   <= MODE_JTAG;
                        r_tgt_direct <= MODE_DIRECT;
                        r_state      <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_drained) r_state <= ST_SWITCH;
                end
                ST_SWITCH: begin
                    JTAGnSWD    <= r_tgt_jtag;
                    JTAG_DIRECT <= r_tgt_direct;
                    r_settle    <= 8'(SETTLE);
                    r_state     <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    r_settle <= r_settle - 8'd1;
                    if (r_settle == 8'd1) begin
                        r_state   <= ST_RUN;
                        MODE_DONE <= 1'b1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_adiv5_arb_ctrl.sv
// Scenario tests plus randomized traffic against a queue-based model of the arbiter.
module tb_adiv5_arb_ctrl;
    localparam int unsigned TD = 4;
    localparam int unsigned ST = 8;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [35:0] A_WRDATA = '0, B_WRDATA = '0, M_WRDATA;
    logic        A_WREN = 1'b0, B_WREN = 1'b0, A_WRFULL, B_WRFULL;
    logic [34:0] A_RDDATA, B_RDDATA, M_RDDATA = '0;
    logic        A_RDEN = 1'b0, B_RDEN = 1'b0, A_RDEMPTY, B_RDEMPTY;
    logic        M_WREN, M_WRFULL = 1'b0, M_RDEN, M_RDEMPTY = 1'b1;
    logic        MODE_REQ = 1'b0, MODE_JTAG = 1'b0, MODE_DIRECT = 1'b0;
    logic        JTAGnSWD, JTAG_DIRECT, MODE_BUSY, MODE_DONE;

    int n_tests = 0;
    int n_fail  = 0;

    adiv5_arb_ctrl #(.TAG_DEPTH(TD), .SETTLE(ST)) dut (
        .CLK(CLK), .RESET(RESET),
        .A_WRDATA(A_WRDATA), .A_WREN(A_WREN), .A_WRFULL(A_WRFULL),
        .A_RDDATA(A_RDDATA), .A_RDEN(A_RDEN), .A_RDEMPTY(A_RDEMPTY),
        .B_WRDATA(B_WRDATA), .B_WREN(B_WREN), .B_WRFULL(B_WRFULL),
        .B_RDDATA(B_RDDATA), .B_RDEN(B_RDEN), .B_RDEMPTY(B_RDEMPTY),
        .M_WRDATA(M_WRDATA), .M_WREN(M_WREN), .M_WRFULL(M_WRFULL),
        .M_RDDATA(M_RDDATA), .M_RDEN(M_RDEN), .M_RDEMPTY(M_RDEMPTY),
        .MODE_REQ(MODE_REQ), .MODE_JTAG(MODE_JTAG), .MODE_DIRECT(MODE_DIRECT),
        .JTAGnSWD(JTAGnSWD), .JTAG_DIRECT(JTAG_DIRECT),
        .MODE_BUSY(MODE_BUSY), .MODE_DONE(MODE_DONE)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        A_WREN = 0; B_WREN = 0; A_RDEN = 0; B_RDEN = 0;
        M_WRFULL = 0; M_RDEMPTY = 1; MODE_REQ = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET = 1;
        tick();
        tick();
        RESET = 0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        #2;
        RESET = 1;
        #1;
        n_tests++;
        if ({JTAGnSWD, JTAG_DIRECT, MODE_BUSY, MODE_DONE} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_mode: got %b expected 1000", {JTAGnSWD, JTAG_DIRECT, MODE_BUSY, MODE_DONE});
        end
        n_tests++;
        if ({A_WRFULL, B_WRFULL, A_RDEMPTY, B_RDEMPTY, M_WREN, M_RDEN} !== 6'b001100) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 001100", {A_WRFULL, B_WRFULL, A_RDEMPTY, B_RDEMPTY, M_WREN, M_RDEN});
        end
        tick();
        RESET = 0;
        tick();
    endtask

    task automatic test_conflict();
        logic [35:0] da, db;
        da = 36'h1_2345_6789;
        db = 36'hA_BCDE_F012;
        A_WRDATA = da; B_WRDATA = db; A_WREN = 1; B_WREN = 1;
        tick();
        A_WREN = 0; B_WREN = 0;
        n_tests++;
        if (M_WREN !== 1'b1 || M_WRDATA !== da) begin
            n_fail++;
            $display("FAIL conflict_first: got wren=%b data=%h expected 1 %h", M_WREN, M_WRDATA, da);
        end
        n_tests++;
        if (A_WRFULL !== 1'b0 || B_WRFULL !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_full: got A=%b B=%b expected A=0 B=1", A_WRFULL, B_WRFULL);
        end
        tick();
        n_tests++;
        if (M_WREN !== 1'b1 || M_WRDATA !== db) begin
            n_fail++;
            $display("FAIL conflict_second: got wren=%b data=%h expected 1 %h", M_WREN, M_WRDATA, db);
        end
        tick();
        n_tests++;
        if (M_WREN !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_idle: got wren=%b expected 0", M_WREN);
        end
    endtask

    // Relies on test_conflict leaving tags A,B outstanding.
    task automatic test_inorder();
        M_RDEMPTY = 0; M_RDDATA = 35'h5_1234_5678;
        #1;
        n_tests++;
        if (A_RDEMPTY !== 1'b0 || B_RDEMPTY !== 1'b1 || A_RDDATA !== M_RDDATA) begin
            n_fail++;
            $display("FAIL inorder_head_a: got Ae=%b Be=%b data=%h expected 0 1 %h", A_RDEMPTY, B_RDEMPTY, A_RDDATA, M_RDDATA);
        end
        B_RDEN = 1;
        #1;
        n_tests++;
        if (M_RDEN !== 1'b0) begin
            n_fail++;
            $display("FAIL inorder_wrong_rden: got M_RDEN=%b expected 0", M_RDEN);
        end
        B_RDEN = 0; A_RDEN = 1;
        #1;
        n_tests++;
        if (M_RDEN !== 1'b1) begin
            n_fail++;
            $display("FAIL inorder_rden_a: got M_RDEN=%b expected 1", M_RDEN);
        end
        tick();
        A_RDEN = 0;
        M_RDDATA = 35'h2_0BAD_CAFE;
        #1;
        n_tests++;
        if (A_RDEMPTY !== 1'b1 || B_RDEMPTY !== 1'b0 || B_RDDATA !== M_RDDATA) begin
            n_fail++;
            $display("FAIL inorder_head_b: got Ae=%b Be=%b data=%h expected 1 0 %h", A_RDEMPTY, B_RDEMPTY, B_RDDATA, M_RDDATA);
        end
        B_RDEN = 1;
        tick();
        B_RDEN = 0;
        #1;
        n_tests++;
        if (A_RDEMPTY !== 1'b1 || B_RDEMPTY !== 1'b1 || M_RDEN !== 1'b0) begin
            n_fail++;
            $display("FAIL inorder_drained: got Ae=%b Be=%b rden=%b expected 1 1 0", A_RDEMPTY, B_RDEMPTY, M_RDEN);
        end
        M_RDEMPTY = 1;
    endtask

    task automatic test_tag_full();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            A_WRDATA = 36'(100 + i);
            A_WREN = 1;
            tick();
        end
        A_WREN = 0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (M_WREN !== 1'b0 || A_WRFULL !== 1'b1) begin
                n_fail++;
                $display("FAIL tagfull_held: got wren=%b Afull=%b expected 0 1", M_WREN, A_WRFULL);
            end
            tick();
        end
        M_RDEMPTY = 0; A_RDEN = 1;
        #1;
        n_tests++;
        if (M_RDEN !== 1'b1 || M_WREN !== 1'b0) begin
            n_fail++;
            $display("FAIL tagfull_pop_cycle: got rden=%b wren=%b expected 1 0", M_RDEN, M_WREN);
        end
        tick();
        M_RDEMPTY = 1; A_RDEN = 0;
        #1;
        n_tests++;
        if (M_WREN !== 1'b1 || M_WRDATA !== 36'd104) begin
            n_fail++;
            $display("FAIL tagfull_release: got wren=%b data=%h expected 1 %h", M_WREN, M_WRDATA, 36'd104);
        end
        tick();
        M_RDEMPTY = 0; A_RDEN = 1;
        repeat (TD) tick();
        idle_inputs();
        #1;
        n_tests++;
        if (M_WREN !== 1'b0 || A_WRFULL !== 1'b0) begin
            n_fail++;
            $display("FAIL tagfull_empty: got wren=%b Afull=%b expected 0 0", M_WREN, A_WRFULL);
        end
    endtask

    task automatic test_mode_switch();
        do_reset();
        A_WRDATA = 36'h0_0000_0ABC; A_WREN = 1;
        tick();
        A_WREN = 0;
        tick();
        MODE_REQ = 1; MODE_JTAG = 0; MODE_DIRECT = 0;
        tick();
        MODE_REQ = 0;
        A_WREN = 1; B_WREN = 1;
        #1;
        n_tests++;
        if (A_WRFULL !== 1'b1 || B_WRFULL !== 1'b1 || MODE_BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_full: got A=%b B=%b busy=%b expected 1 1 1", A_WRFULL, B_WRFULL, MODE_BUSY);
        end
        tick();
        A_WREN = 0; B_WREN = 0;
        M_RDEMPTY = 0;
        #1;
        n_tests++;
        if (M_WREN !== 1'b0 || A_RDEMPTY !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_route: got wren=%b Ae=%b expected 0 0", M_WREN, A_RDEMPTY);
        end
        A_RDEN = 1;
        tick();
        A_RDEN = 0; M_RDEMPTY = 1;
        n_tests++;
        if (JTAGnSWD !== 1'b1 || MODE_BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL switch_early: got jtag=%b busy=%b expected 1 1", JTAGnSWD, MODE_BUSY);
        end
        tick();
        n_tests++;
        if (JTAGnSWD !== 1'b0 || JTAG_DIRECT !== 1'b0) begin
            n_fail++;
            $display("FAIL switch_load: got jtag=%b direct=%b expected 0 0", JTAGnSWD, JTAG_DIRECT);
        end
        for (int i = 0; i < ST - 1; i++) begin
            tick();
            n_tests++;
            if (MODE_DONE !== 1'b0 || MODE_BUSY !== 1'b1) begin
                n_fail++;
                $display("FAIL settle_wait: cycle %0d got done=%b busy=%b expected 0 1", i, MODE_DONE, MODE_BUSY);
            end
        end
        tick();
        n_tests++;
        if (MODE_DONE !== 1'b1 || MODE_BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL settle_done: got done=%b busy=%b expected 1 0", MODE_DONE, MODE_BUSY);
        end
        tick();
        n_tests++;
        if (MODE_DONE !== 1'b0 || JTAGnSWD !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: got done=%b jtag=%b expected 0 0", MODE_DONE, JTAGnSWD);
        end
    endtask

    task automatic test_reset_settle();
        bit saw_done;
        MODE_REQ = 1; MODE_JTAG = 0; MODE_DIRECT = 1;
        tick();
        MODE_REQ = 0;
        tick();
        tick();
        repeat (3) tick();
        n_tests++;
        if (JTAG_DIRECT !== 1'b1 || MODE_BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL settle_pre_reset: got direct=%b busy=%b expected 1 1", JTAG_DIRECT, MODE_BUSY);
        end
        RESET = 1;
        #1;
        n_tests++;
        if (JTAGnSWD !== 1'b1 || JTAG_DIRECT !== 1'b0 || MODE_BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL settle_reset: got jtag=%b direct=%b busy=%b expected 1 0 0", JTAGnSWD, JTAG_DIRECT, MODE_BUSY);
        end
        tick();
        RESET = 0;
        saw_done = 0;
        for (int i = 0; i < 2 * ST; i++) begin
            tick();
            if (MODE_DONE === 1'b1 || MODE_BUSY !== 1'b0) saw_done = 1;
        end
        n_tests++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL settle_no_done: got done/busy activity=1 expected 0");
        end
    endtask

    task automatic test_orphan();
        do_reset();
        M_RDEMPTY = 0; A_RDEN = 1; B_RDEN = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (M_RDEN !== 1'b0 || A_RDEMPTY !== 1'b1 || B_RDEMPTY !== 1'b1) begin
                n_fail++;
                $display("FAIL orphan: got rden=%b Ae=%b Be=%b expected 0 1 1", M_RDEN, A_RDEMPTY, B_RDEMPTY);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [35:0] ha[$];
        logic [35:0] hb[$];
        bit          tq[$];
        bit          last_b;
        bit          issue, pick_b, e_af, e_bf, e_ae, e_be, e_rden;
        logic [35:0] e_data;
        do_reset();
        last_b = 1;
        for (int c = 0; c < 500; c++) begin
            A_WREN = 1'($urandom_range(0, 1));
            B_WREN = 1'($urandom_range(0, 1));
            A_WRDATA = 36'({$urandom(), $urandom()});
            B_WRDATA = 36'({$urandom(), $urandom()});
            M_WRFULL = ($urandom_range(0, 3) == 0);
            M_RDEMPTY = ($urandom_range(0, 2) == 0);
            M_RDDATA = 35'({$urandom(), $urandom()});
            A_RDEN = 1'($urandom_range(0, 1));
            B_RDEN = 1'($urandom_range(0, 1));
            #1;
            issue = !M_WRFULL && (tq.size() < TD) && (ha.size() + hb.size() > 0);
            if (ha.size() > 0 && hb.size() > 0) pick_b = !last_b;
            else pick_b = (hb.size() > 0);
            e_data = pick_b ? (hb.size() > 0 ? hb[0] : '0) : (ha.size() > 0 ? ha[0] : '0);
            e_af = (ha.size() == 1) && !(issue && !pick_b);
            e_bf = (hb.size() == 1) && !(issue && pick_b);
            e_ae = !(!M_RDEMPTY && tq.size() > 0 && tq[0] == 1'b0);
            e_be = !(!M_RDEMPTY && tq.size() > 0 && tq[0] == 1'b1);
            e_rden = (A_RDEN && !e_ae) || (B_RDEN && !e_be);
            n_tests++;
            if (M_WREN !== issue || (issue && M_WRDATA !== e_data)) begin
                n_fail++;
                $display("FAIL rand_issue: cycle %0d got wren=%b data=%h expected %b %h", c, M_WREN, M_WRDATA, issue, e_data);
            end
            n_tests++;
            if ({A_WRFULL, B_WRFULL} !== {e_af, e_bf}) begin
                n_fail++;
                $display("FAIL rand_full: cycle %0d got %b%b expected %b%b", c, A_WRFULL, B_WRFULL, e_af, e_bf);
            end
            n_tests++;
            if ({A_RDEMPTY, B_RDEMPTY, M_RDEN} !== {e_ae, e_be, e_rden}) begin
                n_fail++;
                $display("FAIL rand_route: cycle %0d got %b%b%b expected %b%b%b", c, A_RDEMPTY, B_RDEMPTY, M_RDEN, e_ae, e_be, e_rden);
            end
            n_tests++;
            if (A_RDDATA !== M_RDDATA || B_RDDATA !== M_RDDATA) begin
                n_fail++;
                $display("FAIL rand_rddata: cycle %0d got %h %h expected %h", c, A_RDDATA, B_RDDATA, M_RDDATA);
            end
            if (e_rden) void'(tq.pop_front());
            if (issue) begin
                if (pick_b) void'(hb.pop_front());
                else void'(ha.pop_front());
                tq.push_back(pick_b);
                last_b = pick_b;
            end
            if (A_WREN && !e_af) begin
                ha.delete();
                ha.push_back(A_WRDATA);
            end
            if (B_WREN && !e_bf) begin
                hb.delete();
                hb.push_back(B_WRDATA);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_conflict();
        test_inorder();
        test_tag_full();
        test_mode_switch();
        test_reset_settle();
        test_orphan();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
